store_buffer: RTL and testbench

//   Posted-write FIFO between the core datapath's store port (Mem_WrAddr / Mem_WrData)
//   and a data memory or bus that can back-pressure. Stores retire from the core in one

---
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer.sv | 76 +++++++
 tb/tb_store_buffer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: core store/load snoop port and memory drain port of the store buffer.
interface store_buffer_if #(parameter int PTRW = 2);
  logic            st_valid;
  logic [31:0]     st_addr;
  logic [31:0]     st_data;
  logic [3:0]      st_be;
  logic            st_ready;
  logic            ld_valid;
  logic [31:0]     ld_addr;
  logic [3:0]      ld_be;
  logic            ld_hit;
  logic            ld_conflict;
  logic [31:0]     ld_fwd_data;
  logic            mem_wvalid;
  logic [31:0]     mem_waddr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wbe;
  logic            mem_wready;
  logic            empty;
  logic [PTRW:0]   count;
  modport master (
    output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, ld_be, mem_wready,
    input  st_ready, ld_hit, ld_conflict, ld_fwd_data, mem_wvalid, mem_waddr, mem_wdata,
           mem_wbe, empty, count
  );
  modport slave (
    input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, ld_be, mem_wready,
    output st_ready, ld_hit, ld_conflict, ld_fwd_data, mem_wvalid, mem_waddr, mem_wdata,
           mem_wbe, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO draining to memory in order, with byte-merged load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  logic [29:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [3:0]      be_q   [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
  logic [PTRW:0]   count_q, count_d;
  logic            push, pop;
  logic [3:0]      cov;
  logic [31:0]     fwd;
  logic            unused;
  assign unused = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};
  assign bus.st_ready   = count_q != (PTRW+1)'(DEPTH);
  assign bus.mem_wvalid = count_q != '0;
  assign bus.empty      = count_q == '0;
  assign bus.count      = count_q;
  assign bus.mem_waddr  = {addr_q[rd_ptr_q], 2'b00};
  assign bus.mem_wdata  = data_q[rd_ptr_q];
  assign bus.mem_wbe    = be_q[rd_ptr_q];
  assign push = bus.st_valid & bus.st_ready;
  assign pop  = bus.mem_wvalid & bus.mem_wready;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    count_d  = count_q + (PTRW+1)'(push) - (PTRW+1)'(pop);
    vld_d    = vld_q;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.st_addr[31:2];
      data_q[wr_ptr_q] <= bus.st_data;
      be_q[wr_ptr_q]   <= bus.st_be;
    end
  end
  // Walk entries oldest to youngest so younger matching lanes overwrite older ones.
  always_comb begin
    cov = '0;
    fwd = '0;
    idx = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTRW'(k);
      for (int b = 0; b < 4; b++) begin
        if (vld_q[idx] && addr_q[idx] == bus.ld_addr[31:2] && be_q[idx][b]) begin
          cov[b]        = 1'b1;
          fwd[8*b +: 8] = data_q[idx][8*b +: 8];
        end
      end
    end
  end
  assign bus.ld_fwd_data = fwd;
  assign bus.ld_hit      = bus.ld_valid & ~|(bus.ld_be & ~cov) & |(bus.ld_be & cov);
  assign bus.ld_conflict = bus.ld_valid & |(bus.ld_be & ~cov) & |(bus.ld_be & cov);
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized and directed stimulus against a queue model, with a drain scoreboard.
module tb_store_buffer;
  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  be;
  } entry_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  entry_t m[$];
  entry_t sb_q[$];
  logic last_hit, last_conf;
  logic [31:0] last_fwd, last_cnt;
  store_buffer_if #(.PTRW(2)) bus();
  store_buffer #(.DEPTH(4), .PTRW(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic void check(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endfunction
  // Memory side scoreboard: every accepted drain must match the oldest outstanding store.
  always @(negedge clk) begin
    if (!reset && bus.mem_wvalid === 1'b1 && bus.mem_wready === 1'b1) begin
      if (sb_q.size() == 0) check("drain_unexpected", 32'd1, 32'd0);
      else begin
        entry_t e;
        e = sb_q.pop_front();
        check("drain_addr", bus.mem_waddr, {e.wa, 2'b00});
        check("drain_data", bus.mem_wdata, e.d);
        check("drain_be", {28'd0, bus.mem_wbe}, {28'd0, e.be});
      end
    end
  end
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [3:0] sbe, input logic lv, input logic [31:0] la,
                      input logic [3:0] lbe, input logic wr);
    logic [3:0] cov;
    logic [31:0] fd;
    logic push, pop, eh, ec;
    entry_t e;
    bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd; bus.st_be = sbe;
    bus.ld_valid = lv; bus.ld_addr = la; bus.ld_be = lbe; bus.mem_wready = wr;
    @(negedge clk);
    cov = '0;
    fd = '0;
    for (int b = 0; b < 4; b++)
      for (int i = m.size() - 1; i >= 0; i--)
        if (m[i].wa == la[31:2] && m[i].be[b]) begin
          cov[b] = 1'b1;
          fd[8*b +: 8] = m[i].d[8*b +: 8];
          break;
        end
    eh = lv && (lbe & ~cov) == 0 && (lbe & cov) != 0;
    ec = lv && (lbe & ~cov) != 0 && (lbe & cov) != 0;
    last_hit = bus.ld_hit; last_conf = bus.ld_conflict;
    last_fwd = bus.ld_fwd_data; last_cnt = 32'(bus.count);
    check("count", last_cnt, m.size());
    check("st_ready", 32'(bus.st_ready), 32'(m.size() != 4));
    check("empty", 32'(bus.empty), 32'(m.size() == 0));
    check("mem_wvalid", 32'(bus.mem_wvalid), 32'(m.size() != 0));
    check("ld_hit", 32'(last_hit), 32'(eh));
    check("ld_conflict", 32'(last_conf), 32'(ec));
    check("ld_fwd_data", last_fwd, fd);
    push = sv && m.size() < 4;
    pop = m.size() > 0 && wr;
    @(posedge clk);
    if (pop) void'(m.pop_front());
    if (push) begin
      e.wa = sa[31:2]; e.d = sd; e.be = sbe;
      m.push_back(e);
      sb_q.push_back(e);
    end
    #1;
  endtask
  task automatic do_reset(input logic wr);
    reset = 1'b1;
    bus.st_valid = 1'b0; bus.ld_valid = 1'b0; bus.ld_be = 4'h0; bus.mem_wready = wr;
    @(posedge clk);
    m.delete();
    sb_q.delete();
    #1 reset = 1'b0;
  endtask
  task automatic idle(input logic wr);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, wr);
  endtask
  initial begin
    bus.st_addr = '0; bus.st_data = '0; bus.st_be = '0; bus.ld_addr = '0;
    do_reset(1'b0);
    idle(1'b0);
    check("rst_fwd", last_fwd, 32'h0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h1000 + 32'(i) * 4, 32'hA000 + 32'(i), 4'hF, 1'b0, 32'h0, 4'h0, 1'b0);
    idle(1'b0);
    check("full_count", last_cnt, 32'd4);
    for (int i = 0; i < 5; i++) idle(1'b1);
    check("drained_count", last_cnt, 32'd0);
    step(1'b1, 32'h100, 32'h11223344, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 32'h101, 32'h000000AA, 4'h1, 1'b0, 32'h0, 4'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h102, 4'hF, 1'b0);
    check("t3_hit", 32'(last_hit), 32'd1);
    check("t3_fwd", last_fwd, 32'h112233AA);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100, 4'h0, 1'b0);
    check("be0_hit", 32'(last_hit | last_conf), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    step(1'b1, 32'h200, 32'h00005566, 4'h3, 1'b0, 32'h0, 4'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h200, 4'hF, 1'b1);
    check("t4_conf", 32'(last_conf), 32'd1);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h200, 4'hF, 1'b0);
    check("t4_drained", 32'(last_conf | last_hit), 32'd0);
    for (int i = 0; i < 2; i++)
      step(1'b1, 32'h300 + 32'(i) * 4, 32'hB000 + 32'(i), 4'hF, 1'b0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h400 + 32'(i) * 4, 32'hC000 + 32'(i), 4'(i + 1), 1'b0, 32'h0, 4'h0, 1'b1);
    idle(1'b0);
    check("t5_count", last_cnt, 32'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h500, 32'hD000 + 32'(i), 4'hF, 1'b0, 32'h0, 4'h0, 1'b0);
    do_reset(1'b1);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h500, 4'hF, 1'b0);
    check("t6_count", last_cnt, 32'd0);
    check("t6_fwd", last_fwd, 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, l;
      a = 32'h600 + 32'($urandom_range(0, 2)) * 4 + 32'($urandom_range(0, 3));
      l = 32'h600 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      step(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom), l, 4'($urandom),
           $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 5; i++) idle(1'b1);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
